// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer between the MEM stage and a byte-addressable data memory.
// Splits misaligned halfword/word accesses into byte beats and extends load results.
module lsu_access_sequencer #(
  parameter int AWIDTH           = 32,
  parameter int DWIDTH           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] result_q;
  logic              mis_q;
  logic [1:0]        beat_q;

  logic              accept;
  logic              req_legal;
  logic              req_mis;
  logic              req_err;
  logic              last_beat;
  logic [DWIDTH-1:0] load_ext;

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !req_we_i;
      default:                req_legal = 1'b0;
    endcase
    req_mis = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
              ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    req_err = !req_legal || (req_mis && !ALLOW_MISALIGNED);
  end

  // Only halfword and word accesses can be misaligned, so the split is 2 or 4 beats.
  assign last_beat = (beat_q == (funct3_q[1] ? 2'd3 : 2'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? ERR : ACCESS;
      ACCESS:  if (!mis_q || last_beat) state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ext = result_q;
    case (funct3_q)
      3'b000:  load_ext = DWIDTH'($signed(result_q[7:0]));
      3'b001:  load_ext = DWIDTH'($signed(result_q[15:0]));
      3'b100:  load_ext = DWIDTH'(result_q[7:0]);
      3'b101:  load_ext = DWIDTH'(result_q[15:0]);
      default: load_ext = result_q;
    endcase
  end

  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_funct3_o   = 3'b000;
    rsp_valid_o    = 1'b0;
    rsp_rdata_o    = '0;
    rsp_err_o      = 1'b0;
    case (state_q)
      ACCESS: begin
        mem_read_en_o  = !we_q;
        mem_write_en_o = we_q;
        if (mis_q) begin
          mem_addr_o   = addr_q + AWIDTH'(beat_q);
          mem_funct3_o = we_q ? 3'b000 : 3'b100;
          if (we_q) mem_data_o = DWIDTH'(wdata_q[{beat_q, 3'b000} +: 8]);
        end else begin
          mem_addr_o   = addr_q;
          mem_funct3_o = funct3_q;
          if (we_q) mem_data_o = wdata_q;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = we_q ? '0 : load_ext;
      end
      ERR: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      mis_q    <= 1'b0;
      beat_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        mis_q    <= req_mis;
        beat_q   <= 2'd0;
        result_q <= '0;
      end else if (state_q == ACCESS) begin
        if (!we_q) begin
          if (mis_q) result_q[{beat_q, 3'b000} +: 8] <= mem_data_i[7:0];
          else       result_q <= mem_data_i;
        end
        if (mis_q) beat_q <= last_beat ? 2'd0 : beat_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Directed bench for lsu_access_sequencer: one split-capable instance with a byte memory
// model, and one ALLOW_MISALIGNED=0 instance for the error path.
module tb_lsu_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  bit          sel;

  always #5 clk = ~clk;

  logic        r1_ready, rsp1_valid, rsp1_err, m1_re, m1_we;
  logic [31:0] rsp1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m1_f3;
  logic        r0_ready, rsp0_valid, rsp0_err, m0_re, m0_we;
  logic [31:0] rsp0_rdata, m0_addr, m0_wdata;
  logic [31:0] m0_rdata = 32'hA5A5A5A5;
  logic [2:0]  m0_f3;
  logic        valid1, valid0;

  assign valid1 = req_valid && !sel;
  assign valid0 = req_valid && sel;

  lsu_access_sequencer #(.AWIDTH(32), .DWIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid_i(valid1), .req_ready_o(r1_ready), .req_we_i(req_we), .req_funct3_i(req_f3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp1_valid), .rsp_rdata_o(rsp1_rdata), .rsp_err_o(rsp1_err),
    .mem_addr_o(m1_addr), .mem_data_o(m1_wdata), .mem_read_en_o(m1_re), .mem_write_en_o(m1_we),
    .mem_funct3_o(m1_f3), .mem_data_i(m1_rdata)
  );

  lsu_access_sequencer #(.AWIDTH(32), .DWIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(valid0), .req_ready_o(r0_ready), .req_we_i(req_we), .req_funct3_i(req_f3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp0_valid), .rsp_rdata_o(rsp0_rdata), .rsp_err_o(rsp0_err),
    .mem_addr_o(m0_addr), .mem_data_o(m0_wdata), .mem_read_en_o(m0_re), .mem_write_en_o(m0_we),
    .mem_funct3_o(m0_f3), .mem_data_i(m0_rdata)
  );

  // Little-endian byte memory; reads return the word starting at the address.
  logic [7:0] mem [512];
  logic [8:0] ra;
  assign ra       = m1_addr[8:0];
  assign m1_rdata = {mem[ra + 9'd3], mem[ra + 9'd2], mem[ra + 9'd1], mem[ra]};

  always @(posedge clk) begin
    if (m1_we) begin
      mem[ra] <= m1_wdata[7:0];
      if (m1_f3[1:0] != 2'b00) mem[ra + 9'd1] <= m1_wdata[15:8];
      if (m1_f3[1]) begin
        mem[ra + 9'd2] <= m1_wdata[23:16];
        mem[ra + 9'd3] <= m1_wdata[31:24];
      end
    end
  end

  logic        o_ready, o_rsp_valid, o_err, o_re, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [2:0]  o_f3;
  assign o_ready     = sel ? r0_ready   : r1_ready;
  assign o_rsp_valid = sel ? rsp0_valid : rsp1_valid;
  assign o_err       = sel ? rsp0_err   : rsp1_err;
  assign o_rdata     = sel ? rsp0_rdata : rsp1_rdata;
  assign o_re        = sel ? m0_re      : m1_re;
  assign o_we        = sel ? m0_we      : m1_we;
  assign o_addr      = sel ? m0_addr    : m1_addr;
  assign o_wdata     = sel ? m0_wdata   : m1_wdata;
  assign o_f3        = sel ? m0_f3      : m1_f3;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          lat, n_beats;
  logic [31:0] rsp_d;
  logic        rsp_e, ready_low, quiet;
  logic [31:0] b_addr [8];
  logic [31:0] b_data [8];
  logic [2:0]  b_f3   [8];
  logic        b_wr   [8];

  // Issue one request, trace memory beats until the response, then step to the next IDLE cycle.
  task automatic run_req(input bit s, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = s; req_we = we; req_f3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    check("accept_ready", {31'b0, o_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_f3 = 3'b111; req_addr = ~a; req_wdata = ~d;
    lat = 0; n_beats = 0; ready_low = 1'b1; quiet = 1'b1; rsp_d = 32'hX; rsp_e = 1'bX;
    for (int k = 1; k <= 20; k++) begin
      if (o_ready) ready_low = 1'b0;
      if (o_re || o_we) begin
        if (n_beats < 8) begin
          b_addr[n_beats] = o_addr; b_data[n_beats] = o_wdata;
          b_f3[n_beats] = o_f3;     b_wr[n_beats] = o_we;
        end
        n_beats++;
      end
      if (o_rsp_valid) begin
        lat = k; rsp_d = o_rdata; rsp_e = o_err;
        break;
      end
      if (o_rdata != 0 || o_err) quiet = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_rsp(input string tag, input int exp_lat, input int exp_beats,
                            input logic [31:0] exp_d, input logic exp_e);
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_beats"}, n_beats, exp_beats);
    check({tag, "_rdata"}, rsp_d, exp_d);
    check({tag, "_err"},   {31'b0, rsp_e}, {31'b0, exp_e});
    check({tag, "_ready_low"}, {31'b0, ready_low}, 32'd1);
    check({tag, "_quiet"},     {31'b0, quiet}, 32'd1);
  endtask

  logic [7:0]  exp_b [4];
  logic [31:0] d_a;
  logic [7:0]  rdy_bits, pulse_bits;
  logic        rst_quiet;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enables", {30'b0, m1_re, m1_we}, 32'd0);
    check("rst_rsp", {31'b0, rsp1_valid}, 32'd0);
    check("rst_addr", m1_addr, 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    check("rst_ready", {30'b0, r1_ready, r0_ready}, 32'd3);

    // Aligned store then aligned load of the same word.
    run_req(0, 1'b1, 3'b010, 32'h01000000, 32'hDEADBEEF);
    expect_rsp("sw_al", 2, 1, 32'h0, 1'b0);
    check("sw_al_data", b_data[0], 32'hDEADBEEF);
    check("sw_al_f3", {29'b0, b_f3[0]}, 32'd2);
    run_req(0, 1'b0, 3'b010, 32'h01000000, 32'h0);
    expect_rsp("lw_al", 2, 1, 32'hDEADBEEF, 1'b0);
    check("lw_al_addr", b_addr[0], 32'h01000000);
    check("lw_al_f3", {29'b0, b_f3[0]}, 32'd2);
    check("lw_al_rd", {31'b0, b_wr[0]}, 32'd0);

    // Misaligned word store split into SB beats, then read back through LBU beats.
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    run_req(0, 1'b1, 3'b010, 32'h01000101, 32'h11223344);
    expect_rsp("sw_mis", 5, 4, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("sw_mis_addr", b_addr[k], 32'h01000101 + k);
      check("sw_mis_data", b_data[k], {24'b0, exp_b[k]});
      check("sw_mis_f3", {29'b0, b_f3[k]}, 32'd0);
      check("sw_mis_wr", {31'b0, b_wr[k]}, 32'd1);
    end
    run_req(0, 1'b0, 3'b010, 32'h01000101, 32'h0);
    expect_rsp("lw_mis", 5, 4, 32'h11223344, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("lw_mis_addr", b_addr[k], 32'h01000101 + k);
      check("lw_mis_f3", {29'b0, b_f3[k]}, 32'd4);
    end

    // Byte 3 = 0x80, byte 4 = 0xFF, byte 5 = 0x66.
    run_req(0, 1'b1, 3'b010, 32'h01000000, 32'h80112233);
    run_req(0, 1'b1, 3'b010, 32'h01000004, 32'h445566FF);
    run_req(0, 1'b0, 3'b001, 32'h01000003, 32'h0);
    expect_rsp("lh_mis", 3, 2, 32'hFFFFFF80, 1'b0);
    check("lh_mis_addr0", b_addr[0], 32'h01000003);
    check("lh_mis_addr1", b_addr[1], 32'h01000004);
    check("lh_mis_f3", {29'b0, b_f3[1]}, 32'd4);
    run_req(0, 1'b0, 3'b101, 32'h01000003, 32'h0);
    expect_rsp("lhu_mis", 3, 2, 32'h0000FF80, 1'b0);
    run_req(0, 1'b0, 3'b000, 32'h01000003, 32'h0);
    expect_rsp("lb", 2, 1, 32'hFFFFFF80, 1'b0);
    run_req(0, 1'b0, 3'b100, 32'h01000003, 32'h0);
    expect_rsp("lbu", 2, 1, 32'h00000080, 1'b0);
    run_req(0, 1'b0, 3'b001, 32'h01000004, 32'h0);
    expect_rsp("lh_al", 2, 1, 32'h000066FF, 1'b0);

    // Error paths.
    run_req(1, 1'b0, 3'b010, 32'h01000002, 32'h0);
    expect_rsp("nomis_lw", 1, 0, 32'h0, 1'b1);
    run_req(1, 1'b1, 3'b001, 32'h01000001, 32'h1234);
    expect_rsp("nomis_sh", 1, 0, 32'h0, 1'b1);
    run_req(1, 1'b0, 3'b010, 32'h01000000, 32'h0);
    expect_rsp("nomis_lw_al", 2, 1, 32'hA5A5A5A5, 1'b0);
    run_req(0, 1'b0, 3'b011, 32'h01000000, 32'h0);
    expect_rsp("ill_load", 1, 0, 32'h0, 1'b1);
    run_req(0, 1'b1, 3'b100, 32'h01000000, 32'h0);
    expect_rsp("ill_store", 1, 0, 32'h0, 1'b1);

    // Back-to-back with valid held: LW then SW, second accepted in the cycle after the response.
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010;
    req_addr = 32'h01000000; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h01000008; req_wdata = 32'hCAFEF00D;
    rdy_bits = '0; pulse_bits = '0; d_a = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      rdy_bits[k-1]   = o_ready;
      pulse_bits[k-1] = o_rsp_valid;
      if (k == 2) d_a = o_rdata;
      if (k == 4) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_ready", {24'b0, rdy_bits}, 32'h000000E4);
    check("b2b_pulses", {24'b0, pulse_bits}, 32'h00000012);
    check("b2b_lw_data", d_a, 32'h80112233);
    run_req(0, 1'b0, 3'b010, 32'h01000008, 32'h0);
    expect_rsp("b2b_readback", 2, 1, 32'hCAFEF00D, 1'b0);

    // Reset during beat 2 of a misaligned store.
    run_req(0, 1'b1, 3'b010, 32'h01000020, 32'hAABBCCDD);
    run_req(0, 1'b1, 3'b010, 32'h01000024, 32'hEEFF0011);
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010;
    req_addr = 32'h01000021; req_wdata = 32'h55667788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_beat2_addr", m1_addr, 32'h01000023);
    check("rst_beat2_we", {31'b0, m1_we}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_out", {29'b0, m1_we, m1_re, rsp1_valid}, 32'd0);
    check("rst_mid_addr", m1_addr, 32'd0);
    check("rst_mid_data", m1_wdata, 32'd0);
    rst_quiet = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (rsp1_valid || m1_we) rst_quiet = 1'b0;
    end
    @(negedge clk); rst = 1'b1; #1;
    check("rst_rel_ready", {31'b0, r1_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp1_valid || m1_we) rst_quiet = 1'b0;
    end
    check("rst_no_rsp", {31'b0, rst_quiet}, 32'd1);
    run_req(0, 1'b0, 3'b010, 32'h01000020, 32'h0);
    expect_rsp("rst_readback", 2, 1, 32'hAA7788DD, 1'b0);
    run_req(0, 1'b0, 3'b000, 32'h01000024, 32'h0);
    expect_rsp("rst_byte4", 2, 1, 32'h00000011, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
Load/store sequencer between the MEM pipeline stage and the byte-addressable data memory. It accepts one load/store request at a time over a valid/ready handshake and drives the memory's address, data, read-enable, write-enable and funct3 lines. Misaligned halfword/word accesses are split into byte beats, and load results are reassembled with sign/zero extension. It returns a one-cycle response pulse carrying load data or an error flag.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width; fixed at 32
ALLOW_MISALIGNED, 1, 1: split misaligned accesses into byte beats; 0: flag misaligned as error with no memory access

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  sequencer can accept a request
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RISC-V load/store funct3
req_addr_i  in  AWIDTH  byte address
req_wdata_i  in  DWIDTH  store data, right-aligned
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  DWIDTH  extended load data; 0 for stores and errors
rsp_err_o  out  1  misaligned (ALLOW_MISALIGNED=0) or illegal funct3
mem_addr_o  out  AWIDTH  memory address
mem_data_o  out  DWIDTH  memory write data
mem_read_en_o  out  1  memory read enable
mem_write_en_o  out  1  memory write enable
mem_funct3_o  out  3  memory access size
mem_data_i  in  DWIDTH  memory read data, combinational from mem_addr_o

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, beat counter=0, all captured registers and outputs=0. req_ready_o is 1 once rst=1.
- Reset mid-operation aborts with no response. Store bytes already written stay in memory.
- FSM states are IDLE, ACCESS, RESP, ERR. req_ready_o = (state==IDLE), decoded combinationally.
- IDLE: on req_valid_i && req_ready_o, capture we, funct3, addr and wdata.
  - Legal funct3 for loads: 000, 001, 010, 100, 101. For stores: 000, 001, 010.
  - Size is 1/2/4 bytes for funct3[1:0] = 00/01/10.
  - Misaligned when size=2 and addr[0]=1, or size=4 and addr[1:0]≠0.
  - Illegal funct3, or misaligned with ALLOW_MISALIGNED=0 -> ERR. Otherwise -> ACCESS with beat=0.
- ACCESS, aligned: one cycle.
  - mem_addr_o = addr and mem_funct3_o = funct3.
  - Load: mem_read_en_o=1, register mem_data_i as the result. Store: mem_write_en_o=1, mem_data_o = wdata.
  - Next state RESP.
- ACCESS, misaligned: one beat per byte, k = 0..size-1, one beat per cycle.
  - mem_addr_o = addr+k, wrapping modulo 2^AWIDTH.
  - Load: mem_funct3_o = 100 (LBU), mem_read_en_o=1, mem_data_i[7:0] stored into result byte k.
  - Store: mem_funct3_o = 000 (SB), mem_write_en_o=1, mem_data_o = {24'b0, wdata byte k}.
  - After beat size-1 -> RESP.
- Outside ACCESS: mem_read_en_o = mem_write_en_o = 0, and mem_addr_o, mem_data_o, mem_funct3_o are 0.
- RESP: rsp_valid_o=1 and rsp_err_o=0.
  - Load rsp_rdata_o: extended per funct3 (LB/LH sign-extend; LBU/LHU zero-extend; LW as assembled).
  - Store rsp_rdata_o = 0.
  - Next state IDLE.
- ERR: rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0, no memory access, next state IDLE.
- Latency from acceptance cycle T:
  - aligned: access T+1, response T+2;
  - misaligned halfword: response T+3;
  - misaligned word: response T+5;
  - error: response T+1.
- No request is accepted during ACCESS, RESP or ERR. The next acceptance is the first IDLE cycle after the response.
- req_* inputs are ignored when not accepted, and captured values are immune to later input changes.
- rsp_* outputs are 0 in every cycle other than RESP/ERR.

Test Plan:
- Aligned LW at 0x01000000, memory word 0xDEADBEEF -> one read cycle with funct3=010, then rsp_valid_o pulse with rsp_rdata_o=0xDEADBEEF at T+2, rsp_err_o=0.
- SW 0x11223344 to 0x01000101, ALLOW_MISALIGNED=1 -> four SB beats at 0x01000101..0x01000104 with data 0x44, 0x33, 0x22, 0x11; a following LW at 0x01000101 returns 0x11223344 at T+5.
- LH at 0x01000003, bytes [3]=0x80, [4]=0xFF -> two LBU beats, rsp_rdata_o=0xFFFFFF80; LHU at the same address -> 0x0000FF80.
- ALLOW_MISALIGNED=0, LW at 0x01000002 -> no mem enables asserted; rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 at T+1. Load funct3=011 and store funct3=100 -> error response likewise.
- Back-to-back requests held valid -> req_ready_o low from T+1 through the response cycle; second request accepted the cycle after the response; no request dropped or duplicated.
- rst asserted during beat 2 of a misaligned SW -> outputs 0 immediately, no response pulse, bytes 0–1 written and bytes 2–3 unchanged; req_ready_o=1 after rst deasserts.
